lsu_mem_port: RTL and testbench

Load/store responder for the RV32I core. Executes the data-memory transactions requested by the decoder's `MemRead`/`MemWrite` strobes: aligns addresses, generates byte enables, replicates store data, runs a req/ack handshake with word-wide data memory, and sign- or zero-extends load data. It sits between the execute stage (ALU address, rs2 data, funct3) and the data memory. It holds the pipeline with `stall` until the access completes.

---
 rtl/lsu_mem_port.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit front end with a req/ack word-memory port.
// Revision: 1.0
`default_nettype none

module lsu_mem_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;

    logic        w_any_req;
    logic        w_store;
    logic        w_size_ok;
    logic        w_legal;
    logic        w_accept;
    logic        w_reject;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    assign w_any_req = MemRead | MemWrite;
    assign w_store   = MemWrite;

    always_comb begin
        w_size_ok = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = wdata;
        case (funct[1:0])
            2'b00: begin
                w_size_ok = 1'b1;
                w_be      = 4'b0001 << addr[1:0];
                w_wdata   = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_size_ok = ~addr[0];
                w_be      = 4'b0011 << addr[1:0];
                w_wdata   = {2{wdata[15:0]}};
            end
            2'b10: begin
                w_size_ok = (addr[1:0] == 2'b00);
            end
            default: begin
                w_size_ok = 1'b0;
            end
        endcase
        if (!w_store) begin
            w_be = 4'b1111;
        end
    end

    // Stores have no unsigned variants; LWU (110) does not exist on RV32.
    assign w_legal  = w_size_ok & (w_store ? ~funct[2] : (funct != 3'b110));
    assign w_accept = (r_state == S_IDLE) & w_any_req & w_legal;
    assign w_reject = (r_state == S_IDLE) & w_any_req & ~w_legal;

    assign stall      = reset & (w_accept | (r_state == S_REQ));
    assign misaligned = reset & w_reject;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
            S_REQ:   if (mem_ack)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_funct[1:0])
            2'b00:   w_ext = {{24{~r_funct[2] & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_ext = {{16{~r_funct[2] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
            r_funct <= 3'h0;
            r_off   <= 2'h0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req   <= 1'b1;
                r_we    <= w_store;
                r_addr  <= {addr[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_funct <= funct;
                r_off   <= addr[1:0];
            end else if (r_state == S_REQ && mem_ack) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_rdata <= w_ext;
                end
            end
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: table-driven and randomized checks of lsu_mem_port.
// Revision: 1.0
`default_nettype none

module tb_lsu_mem_port;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;
    int n_rise   = 0;
    int n_exp    = 0;
    logic        prev_req = 1'b0;
    logic [31:0] m_rdata  = 32'h0;

    lsu_mem_port dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct      (funct),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req && !prev_req) n_rise++;
        prev_req = mem_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules, expressed as access sizes in bytes and arithmetic.
    function automatic int m_bytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic logic m_legal(input logic st, input logic [2:0] f, input logic [31:0] a);
        if (f[1:0] == 2'b11) return 1'b0;
        if ((a % m_bytes(f)) != 0) return 1'b0;
        if (st) return (f[2] == 1'b0);
        return (f != 3'b110);
    endfunction

    function automatic logic [3:0] m_be(input logic st, input logic [2:0] f, input logic [31:0] a);
        int lanes;
        if (!st) return 4'hF;
        lanes = (1 << m_bytes(f)) - 1;
        return 4'((lanes << (a % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] w);
        case (m_bytes(f))
            1:       return (w & 32'hFF) * 32'h01010101;
            2:       return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] m);
        logic [31:0] v;
        logic [31:0] mask;
        int nb;
        nb = m_bytes(f);
        if (nb == 4) return m;
        mask = (nb == 1) ? 32'hFF : 32'hFFFF;
        v = (m >> (8 * (a % 4))) & mask;
        if (!f[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Starts at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mr,
                          input int waits, input logic emis, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        int nst;
        MemRead = rd; MemWrite = wr; funct = f; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("misaligned", misaligned, emis);
        if (emis) begin
            chk("stall_illegal", stall, 0);
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            chk("mem_req_illegal", mem_req, 0);
            chk("misaligned_clear", misaligned, 0);
            chk("rdata_hold_illegal", rdata, erd);
        end else begin
            n_exp++;
            chk("stall_accept", stall, 1);
            nst = stall ? 1 : 0;
            for (int i = 0; i <= waits; i++) begin
                @(negedge clk);
                chk("mem_req", mem_req, 1);
                chk("mem_we", mem_we, wr);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_be", mem_be, ebe);
                if (wr) chk("mem_wdata", mem_wdata, ewd);
                if (i == waits) begin
                    mem_ack = 1'b1; mem_rdata = mr;
                end else begin
                    mem_ack = 1'b0; mem_rdata = ~mr;
                end
                #1;
                if (stall) nst++;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'h0;
            #1;
            chk("stall_done", stall, 0);
            chk("mem_req_done", mem_req, 0);
            chk("rdata", rdata, erd);
            chk("stall_cycles", nst, waits + 2);
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mr;
        int          waits;
        logic        emis;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h1004, 32'h0,        32'hDEADBEEF, 0, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h2003, 32'h0,        32'h80FF1234, 0, 1'b0, 4'hF, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h2003, 32'h0,        32'h80FF1234, 1, 1'b0, 4'hF, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b1, 1'b0, 3'b001, 32'h2002, 32'h0,        32'h80FF1234, 0, 1'b0, 4'hF, 32'h0,        32'hFFFF80FF};
        tbl[4]  = '{1'b0, 1'b1, 3'b000, 32'h1001, 32'h123456AB, 32'h0,        0, 1'b0, 4'b0010, 32'hABABABAB, 32'hFFFF80FF};
        tbl[5]  = '{1'b0, 1'b1, 3'b001, 32'h1002, 32'h123456AB, 32'h0,        2, 1'b0, 4'b1100, 32'h56AB56AB, 32'hFFFF80FF};
        tbl[6]  = '{1'b1, 1'b0, 3'b010, 32'h1002, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        tbl[7]  = '{1'b0, 1'b1, 3'b001, 32'h1001, 32'h55AA55AA, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        tbl[8]  = '{1'b1, 1'b0, 3'b101, 32'h2002, 32'h0,        32'h80FF1234, 3, 1'b0, 4'hF, 32'h0,        32'h000080FF};
        tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h3000, 32'hCAFEF00D, 32'h0,        0, 1'b0, 4'hF, 32'hCAFEF00D, 32'h000080FF};
        tbl[10] = '{1'b1, 1'b0, 3'b110, 32'h4000, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h000080FF};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h4001, 32'h11223344, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h000080FF};
        tbl[12] = '{1'b1, 1'b0, 3'b011, 32'h4000, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h000080FF};
        tbl[13] = '{1'b1, 1'b1, 3'b010, 32'h5008, 32'h01020304, 32'h0,        1, 1'b0, 4'hF, 32'h01020304, 32'h000080FF};

        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; funct = 3'b011;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_misaligned_gated", misaligned, 0);
        funct = 3'b010;
        #1;
        chk("rst_stall_gated", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        MemRead = 1'b0; reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].f, tbl[i].a, tbl[i].wd, tbl[i].mr,
                   tbl[i].waits, tbl[i].emis, tbl[i].ebe, tbl[i].ewd, tbl[i].erd);
        end
        m_rdata = 32'h000080FF;

        // Reset pulled mid-REQ, then a stray ack while idle.
        MemRead = 1'b1; funct = 3'b010; addr = 32'h40;
        @(negedge clk);
        n_exp++;
        chk("midrst_req_before", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("midrst_stall_gated", stall, 0);
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_rdata", rdata, 0);
        reset = 1'b1; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        chk("late_ack_mem_req", mem_req, 0);
        chk("late_ack_rdata", rdata, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_idle_req", mem_req, 0);
        m_rdata = 32'h0;
        access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'hA5A5C3C3, 0, 1'b0, 4'hF, 32'h0, 32'hA5A5C3C3);
        m_rdata = 32'hA5A5C3C3;

        for (int n = 0; n < 60; n++) begin
            logic        rd, wr, st, lg;
            logic [2:0]  f;
            logic [31:0] a, wd, mr, erd;
            int          kind, w;
            kind = $urandom_range(1, 3);
            rd = kind[0]; wr = kind[1]; st = wr;
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            mr = $urandom;
            w  = $urandom_range(0, 3);
            lg = m_legal(st, f, a);
            erd = m_rdata;
            if (lg && !st) erd = m_load(f, a, mr);
            access(rd, wr, f, a, wd, mr, w, !lg, m_be(st, f, a), m_wdata(f, wd), erd);
            m_rdata = erd;
        end

        @(negedge clk);
        chk("req_count", n_rise, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
